// File: rtl/layer_argmax.sv
// Streaming argmax over M-element signed vectors. Elements arrive one beat at a time
// and the (index, value) of the maximum is held until the consumer takes it.
// Optional macro LAYER_ARGMAX_TIE_LAST_EN: the last of several equal maxima wins.
module layer_argmax #(
    parameter int M  = 5,
    parameter int T  = 9,
    localparam int IW = ($clog2(M) > 1) ? $clog2(M) : 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                s_valid,
    output logic                s_ready,
    input  logic signed [T-1:0] data_in,
    output logic                m_valid,
    input  logic                m_ready,
    output logic [IW-1:0]       idx_out,
    output logic signed [T-1:0] max_out
);

    typedef enum logic {ACCUM, HOLD} state_t;

    localparam logic [IW-1:0] LAST = IW'(M - 1);

    state_t        state, state_nxt;
    logic [IW-1:0] cnt;
    logic          beat, last, better, take;

    // The running max lives directly in the output registers; it is only
    // meaningful to the consumer once the FSM reaches HOLD.
`ifdef LAYER_ARGMAX_TIE_LAST_EN
    assign better = (data_in >= max_out);
`else
    assign better = (data_in > max_out);
`endif

    always_comb begin
        state_nxt = state;
        s_ready   = 1'b0;
        m_valid   = 1'b0;
        beat      = 1'b0;
        last      = (cnt == LAST);
        take      = 1'b0;
        case (state)
            ACCUM: begin
                s_ready = 1'b1;
                beat    = s_valid;
                // first element of a vector is loaded regardless of the old max
                take    = s_valid && ((cnt == '0) || better);
                if (s_valid && last)
                    state_nxt = HOLD;
            end
            HOLD: begin
                m_valid = 1'b1;
                if (m_ready)
                    state_nxt = ACCUM;
            end
            default: state_nxt = ACCUM;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= ACCUM;
            cnt     <= '0;
            idx_out <= '0;
            max_out <= '0;
        end else begin
            state <= state_nxt;
            if (beat)
                cnt <= last ? '0 : cnt + IW'(1);
            if (take) begin
                max_out <= data_in;
                idx_out <= cnt;
            end
        end
    end

endmodule

// File: tb/tb_layer_argmax.sv
// Bench for layer_argmax: table of vectors plus hand sequences for stall/reset corners,
// results checked against a queue of expected (index, max) pairs.
module tb_layer_argmax;

    logic              clk = 1'b0;
    logic              reset;
    logic              s_valid;
    logic              s_ready;
    logic signed [8:0] data_in;
    logic              m_valid;
    logic              m_ready;
    logic [2:0]        idx_out;
    logic signed [8:0] max_out;

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic [4:0][8:0] d;
        logic [15:0]     pat;
        int              plen;
        int              idx;
        int              mx;
    } vec_t;

    typedef struct {
        int idx;
        int mx;
    } exp_t;

    exp_t q[$];
    vec_t tbl[7];

    layer_argmax #(.M(5), .T(9)) dut (
        .clk(clk), .reset(reset),
        .s_valid(s_valid), .s_ready(s_ready), .data_in(data_in),
        .m_valid(m_valid), .m_ready(m_ready),
        .idx_out(idx_out), .max_out(max_out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    function automatic vec_t mk(input int a0, input int a1, input int a2, input int a3,
                                input int a4, input logic [15:0] pat, input int plen,
                                input int idx, input int mx);
        vec_t v;
        v.d[0] = 9'(a0); v.d[1] = 9'(a1); v.d[2] = 9'(a2);
        v.d[3] = 9'(a3); v.d[4] = 9'(a4);
        v.pat = pat; v.plen = plen; v.idx = idx; v.mx = mx;
        return v;
    endfunction

    // Result scoreboard: a handshake completes on the next rising edge.
    always @(negedge clk) begin
        if (!reset && m_valid && m_ready) begin
            if (q.size() == 0) begin
                chk("unexpected_result", 1, 0);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("idx_out", int'(idx_out), e.idx);
                chk("max_out", int'(max_out), e.mx);
            end
        end
    end

    // Called at posedge+1; returns at posedge+1 of the cycle after the last beat.
    task automatic send(input vec_t v, input bit push);
        int  n = 0;
        int  i = 0;
        bit  acc;
        if (push) q.push_back('{idx: v.idx, mx: v.mx});
        while (n < 5 && i < 60) begin
            s_valid = (i < v.plen) ? v.pat[i] : 1'b1;
            data_in = v.d[n];
            acc = s_valid && s_ready;
            @(posedge clk); #1;
            if (acc) n++;
            i++;
        end
        s_valid = 1'b0;
        if (n < 5) chk("send_timeout", n, 5);
        chk("m_valid_latency", int'(m_valid), 1);
        chk("s_ready_in_hold", int'(s_ready), 0);
        if (m_ready) begin
            @(posedge clk); #1;
            chk("s_ready_after_hs", int'(s_ready), 1);
            chk("m_valid_after_hs", int'(m_valid), 0);
        end
    endtask

    initial begin
        vec_t v;
        int   w;
`ifdef LAYER_ARGMAX_TIE_LAST_EN
        tbl[0] = mk(3, -2, 7, 7, 1,            16'h1, 0, 3, 7);
        tbl[1] = mk(-5, -3, -9, -3, -4,        16'h1, 0, 3, -3);
        tbl[3] = mk(-256, -256, -256, -256, -256, 16'h1, 0, 4, -256);
        tbl[4] = mk(255, -1, 0, 254, 255,      16'h1, 0, 4, 255);
`else
        tbl[0] = mk(3, -2, 7, 7, 1,            16'h1, 0, 2, 7);
        tbl[1] = mk(-5, -3, -9, -3, -4,        16'h1, 0, 1, -3);
        tbl[3] = mk(-256, -256, -256, -256, -256, 16'h1, 0, 0, -256);
        tbl[4] = mk(255, -1, 0, 254, 255,      16'h1, 0, 0, 255);
`endif
        // valid sequence 1,0,0,1,0,1,1,0,1 (bit i = cycle i)
        tbl[2] = mk(8, 1, 2, 9, 4,             16'b1_0110_1001, 9, 3, 9);
        tbl[5] = mk(-1, -2, -3, -4, -100,      16'h1, 0, 0, -1);
        tbl[6] = mk(1, 2, 3, 4, 5,             16'h1, 0, 4, 5);

        reset = 1'b1; s_valid = 1'b0; data_in = '0; m_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        chk("rst_s_ready", int'(s_ready), 1);
        chk("rst_m_valid", int'(m_valid), 0);
        chk("rst_idx", int'(idx_out), 0);
        chk("rst_max", int'(max_out), 0);

        m_ready = 1'b1;
        for (int k = 0; k < 7; k++) send(tbl[k], 1'b1);

        // Stalled result: outputs hold, s_valid ignored while in HOLD.
        m_ready = 1'b0;
        send(mk(0, 0, 0, 0, 12, 16'h1, 0, 4, 12), 1'b1);
        for (int k = 0; k < 4; k++) begin
            s_valid = 1'b1; data_in = 9'sd100;
            @(posedge clk); #1;
            chk("stall_m_valid", int'(m_valid), 1);
            chk("stall_s_ready", int'(s_ready), 0);
            chk("stall_idx", int'(idx_out), 4);
            chk("stall_max", int'(max_out), 12);
        end
        s_valid = 1'b0; m_ready = 1'b1;
        @(posedge clk); #1;
        chk("stall_release_s_ready", int'(s_ready), 1);
        send(tbl[6], 1'b1);

        // Reset after a partial vector.
        for (int k = 0; k < 3; k++) begin
            s_valid = 1'b1; data_in = 9'(50 + 10 * k);
            @(posedge clk); #1;
        end
        s_valid = 1'b0; reset = 1'b1;
        @(posedge clk); #1 reset = 1'b0;
        chk("midvec_rst_max", int'(max_out), 0);
        chk("midvec_rst_s_ready", int'(s_ready), 1);
        send(tbl[6], 1'b1);

        // Reset while a result is pending.
        m_ready = 1'b0;
        send(mk(100, 20, 30, 40, 50, 16'h1, 0, 0, 100), 1'b0);
        reset = 1'b1;
        @(posedge clk); #1 reset = 1'b0;
        chk("hold_rst_m_valid", int'(m_valid), 0);
        chk("hold_rst_idx", int'(idx_out), 0);
        m_ready = 1'b1;
        send(mk(-7, -8, -6, -9, -10, 16'h1, 0, 2, -6), 1'b1);

        w = 0;
        while (q.size() != 0 && w < 20) begin
            @(posedge clk); #1; w++;
        end
        chk("queue_drain", q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/layer_argmax.md
LAYER_ARGMAX -- requirements
Module: layer_argmax

Interface
REQ-001 The block SHALL have parameter M, default 5, meaning the number of elements per input vector (M >= 2).
REQ-002 The block SHALL have parameter T, default 9, meaning the element width in bits, signed two's complement.
REQ-003 The block SHALL have derived localparam IW = max(1, $clog2(M)), the index width.
REQ-004 The block SHALL have port clk, input, 1 bit, the clock; all state updates on its rising edge.
REQ-005 The block SHALL have port reset, input, 1 bit, the reset: reset reset, synchronous, active-high; clock clk.
REQ-006 The block SHALL have port s_valid, input, 1 bit, meaning the upstream element on data_in is valid.
REQ-007 The block SHALL have port s_ready, output, 1 bit, meaning the block accepts an element this cycle.
REQ-008 The block SHALL have port data_in, input, T bits signed, carrying one layer output element per beat, in index order 0..M-1.
REQ-009 The block SHALL have port m_valid, output, 1 bit, meaning a result is available.
REQ-010 The block SHALL have port m_ready, input, 1 bit, meaning the downstream consumer takes the result.
REQ-011 The block SHALL have port idx_out, output, IW bits, giving the index of the maximum element.
REQ-012 The block SHALL have port max_out, output, T bits signed, giving the maximum element value.

Function
REQ-013 The block SHALL implement two states: ACCUM (collect elements) and HOLD (present result).
REQ-014 s_ready SHALL be 1 exactly when state==ACCUM; a beat is accepted when s_valid && s_ready.
REQ-015 Element counter cnt (0..M-1) SHALL increment per accepted beat and wrap to 0 on the M-th beat.
REQ-016 On an accepted beat with cnt==0, the running max SHALL load data_in and the running index SHALL load 0, unconditionally.
REQ-017 On an accepted beat with cnt>0, the block SHALL update the max/index with data_in/cnt when data_in > max (signed compare); the tie rule is set per REQ-027.
REQ-018 The accepted beat with cnt==M-1 SHALL move the state to HOLD; m_valid SHALL rise the next cycle (latency 1 cycle from last accepted beat).
REQ-019 In HOLD, m_valid=1 and idx_out/max_out SHALL remain stable until m_valid && m_ready.
REQ-020 On m_valid && m_ready, the state SHALL return to ACCUM next cycle and m_valid SHALL fall; s_ready SHALL be 1 that next cycle.
REQ-021 Gaps (s_valid=0) in ACCUM SHALL not alter cnt, max or index.
REQ-022 s_valid asserted during HOLD SHALL be ignored (no beat accepted, no state change).
REQ-023 idx_out and max_out SHALL be driven from registers only (no combinational path from data_in).
REQ-024 No arithmetic beyond the signed compare SHALL be performed; values SHALL never be truncated or extended.

Reset
REQ-025 On reset: state=ACCUM, cnt=0, m_valid=0, idx_out=0, max_out=0; s_ready=1 the cycle after reset deasserts.
REQ-026 Reset asserted mid-vector or in HOLD SHALL discard the partial vector or pending result; the next M accepted beats SHALL form a fresh vector.

Configuration
REQ-027 Macro LAYER_ARGMAX_TIE_LAST_EN: when defined, the update condition SHALL be data_in >= max (the last of equal maxima wins); when undefined, it SHALL be data_in > max (the first wins).

Verification
REQ-028 M=5,T=9, inputs [3,-2,7,7,1] back-to-back, m_ready=1 -> m_valid one cycle after beat 4, max_out=7, idx_out=2 (macro off) / 3 (macro on).
REQ-029 Inputs [-5,-3,-9,-3,-4] -> max_out=-3, idx_out=1 (macro off) / 3 (macro on); confirms signed compare.
REQ-030 Inputs [0,0,0,0,12], m_ready held 0 for 4 cycles after m_valid -> m_valid, idx_out=4 and max_out=12 stable; s_ready=0 throughout; s_valid pulses ignored.
REQ-031 s_valid toggled 1,0,0,1,0,1,1,0,1 with [8,1,2,9,4] -> idx_out=3, max_out=9; cnt unaffected by gaps.
REQ-032 Reset after 3 accepted beats [50,60,70], then [1,2,3,4,5] -> idx_out=4, max_out=5 (no carry-over of 70).
REQ-033 Two vectors back-to-back with m_ready=1 -> s_ready high the cycle after the first handshake; second result correct and independent of the first.
